// File: rtl/sync_fifo_ptr_sync.sv
// Multi-stage synchronizer for a Gray-coded CDC FIFO pointer, with registered
// binary decode, change pulse, sticky Gray-violation flag and flush indication.
module sync_fifo_ptr_sync #(
    parameter int WIDTH       = 4,
    parameter int STAGES      = 2,
    parameter bit GRAY_DECODE = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] ptr_gray_in,
    input  logic             err_clr,
    output logic [WIDTH-1:0] ptr_gray_out,
    output logic [WIDTH-1:0] ptr_bin_out,
    output logic             ptr_update,
    output logic             gray_err,
    output logic             sync_valid
);

    localparam int CNT_W = $clog2(STAGES + 2);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STAGES + 1);

    function automatic logic [WIDTH-1:0] g2b(input logic [WIDTH-1:0] g);
        logic [WIDTH-1:0] b;
        b[WIDTH-1] = g[WIDTH-1];
        for (int i = WIDTH - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    function automatic int unsigned popcount(input logic [WIDTH-1:0] v);
        int unsigned n;
        n = 0;
        for (int i = 0; i < WIDTH; i++) begin
            n = n + 32'(v[i]);
        end
        return n;
    endfunction

    logic [WIDTH-1:0] sync_stage [STAGES];
    logic [WIDTH-1:0] gray_q;
    logic [CNT_W-1:0] start_cnt;
    logic             changed;
    logic             violation;

    assign ptr_gray_out = sync_stage[STAGES-1];
    assign sync_valid   = (start_cnt == CNT_LAST);
    assign changed      = (ptr_gray_out != gray_q);
    assign violation    = (popcount(ptr_gray_out ^ gray_q) > 1);

    // Synchronizer chain: flop-to-flop only, nothing between stages.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < STAGES; i++) begin
                sync_stage[i] <= '0;
            end
        end else begin
            sync_stage[0] <= ptr_gray_in;
            for (int i = 1; i < STAGES; i++) begin
                sync_stage[i] <= sync_stage[i-1];
            end
        end
    end

    // Decode stage: previous sample plus registered binary (or raw Gray) pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gray_q      <= '0;
            ptr_bin_out <= '0;
        end else begin
            gray_q      <= ptr_gray_out;
            ptr_bin_out <= GRAY_DECODE ? g2b(ptr_gray_out) : ptr_gray_out;
        end
    end

    // Flush counter saturates once the chain and decode stage hold real samples.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            start_cnt <= '0;
        end else if (!sync_valid) begin
            start_cnt <= start_cnt + CNT_W'(1);
        end
    end

    // Set beats clear when a violation and err_clr land on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_update <= 1'b0;
            gray_err   <= 1'b0;
        end else begin
            ptr_update <= changed && sync_valid;
            if (violation && sync_valid) begin
                gray_err <= 1'b1;
            end else if (err_clr) begin
                gray_err <= 1'b0;
            end
        end
    end

endmodule
